swc_prog: RTL

Programmable stopwatch/counter core, the parametrised successor of the 24-bit Swc counter. It accepts 12-bit instructions (4-bit opcode, 8-bit immediate) and adds the following over Swc:
- counter width set as a whole number of bytes, loaded through a byte pointer;
- programmable prescaler for continuous counting;
- wrap mode, a terminal-count pulse and an explicit error flag.

It sits under the same instruction-issuing controller as Swc.

---
 rtl/swc_prog.sv | 133 +++++++++++++
 1 files changed

// File: rtl/swc_prog.sv
// Programmable stopwatch/counter core: byte-loadable W-bit counter with single steps,
// prescaled continuous up/down counting, optional wrap-around and a sticky error state.
module swc_prog #(
  parameter int BYTES = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [11:0]          inst,
  input  logic                 inst_wen,
  output logic [8*BYTES-1:0]   counter,
  output logic                 ready,
  output logic                 zero,
  output logic                 error
);

  localparam int W = 8*BYTES;
  localparam logic [7:0] BYTES_IMM = 8'(BYTES);
  localparam logic [3:0] LAST_PTR  = 4'(BYTES-1);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDB = 4'h1;
  localparam logic [3:0] OP_SBP = 4'h2;
  localparam logic [3:0] OP_COU = 4'h3;
  localparam logic [3:0] OP_COD = 4'h4;
  localparam logic [3:0] OP_CCU = 4'h5;
  localparam logic [3:0] OP_CCD = 4'h6;
  localparam logic [3:0] OP_CCS = 4'h7;
  localparam logic [3:0] OP_PRE = 4'h8;
  localparam logic [3:0] OP_MOD = 4'h9;

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_ERROR} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   counter_q, counter_d;
  logic [3:0]     ptr_q, ptr_d;
  logic [7:0]     pre_q, pre_d;
  logic [7:0]     pcnt_q, pcnt_d;
  logic           wrap_q, wrap_d;
  logic           zero_q, zero_d;

  logic [3:0]     opcode;
  logic [7:0]     imm;
  logic           reissue;
  logic           stepping;
  logic [W-1:0]   stepped;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
      ptr_q     <= '0;
      pre_q     <= '0;
      pcnt_q    <= '0;
      wrap_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      ptr_q     <= ptr_d;
      pre_q     <= pre_d;
      pcnt_q    <= pcnt_d;
      wrap_q    <= wrap_d;
      zero_q    <= zero_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    ptr_d     = ptr_q;
    pre_d     = pre_q;
    pcnt_d    = pcnt_q;
    wrap_d    = wrap_q;
    zero_d    = 1'b0;

    opcode = inst[11:8];
    imm    = inst[7:0];

    // A same-direction reissue lets the prescaler run on instead of interrupting it
    reissue  = inst_wen && ((state_q == S_UP   && opcode == OP_CCU) ||
                            (state_q == S_DOWN && opcode == OP_CCD));
    stepping = (state_q == S_UP || state_q == S_DOWN) && (!inst_wen || reissue);
    stepped  = (state_q == S_UP) ? counter_q + W'(1) : counter_q - W'(1);

    if (state_q != S_ERROR) begin
      if (inst_wen && !reissue) begin
        state_d = S_IDLE;
        case (opcode)
          OP_NOP: ;
          OP_LDB: begin
            counter_d[8*ptr_q +: 8] = imm;
            ptr_d = (ptr_q == LAST_PTR) ? 4'd0 : ptr_q + 4'd1;
          end
          OP_SBP: begin
            if (imm >= BYTES_IMM) state_d = S_ERROR;
            else                  ptr_d   = imm[3:0];
          end
          OP_COU: counter_d = counter_q + W'(1);
          OP_COD: counter_d = counter_q - W'(1);
          OP_CCU: begin
            state_d = S_UP;
            pcnt_d  = '0;
          end
          OP_CCD: begin
            state_d = S_DOWN;
            pcnt_d  = '0;
          end
          OP_CCS: counter_d = '0;
          OP_PRE: pre_d  = imm;
          OP_MOD: wrap_d = imm[0];
          default: state_d = S_ERROR;
        endcase
      end else if (stepping) begin
        if (pcnt_q == pre_q) begin
          counter_d = stepped;
          pcnt_d    = '0;
          if (stepped == '0) begin
            zero_d = 1'b1;
            if (!wrap_q && !reissue) state_d = S_IDLE;
          end
        end else begin
          pcnt_d = pcnt_q + 8'd1;
        end
      end
    end
  end

  assign counter = counter_q;
  assign ready   = (state_q == S_IDLE);
  assign error   = (state_q == S_ERROR);
  assign zero    = zero_q;

endmodule
